// File: rtl/bip_pkg.sv
// Shared definitions for the BIP control unit: opcodes, FSM states and
// the bundle of datapath controls produced by the instruction decoder.
package bip_pkg;

   localparam int OPC_W = 5;

   localparam logic [OPC_W-1:0] OPC_HLT  = 5'b00000;
   localparam logic [OPC_W-1:0] OPC_STO  = 5'b00001;
   localparam logic [OPC_W-1:0] OPC_LD   = 5'b00010;
   localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00011;
   localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00100;
   localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00101;
   localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00110;
   localparam logic [OPC_W-1:0] OPC_SUBI = 5'b00111;

   localparam logic [1:0] SEL_A_MEM = 2'b00;
   localparam logic [1:0] SEL_A_IMM = 2'b01;
   localparam logic [1:0] SEL_A_ALU = 2'b10;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'b00,
      ST_DECODE = 2'b01,
      ST_EXEC   = 2'b10,
      ST_HALT   = 2'b11
   } state_t;

   typedef struct packed {
      logic [1:0] selA;
      logic       selB;
      logic       opCode;
      logic       wrAcc;
      logic       dataRd;
      logic       dataWr;
   } ctrl_t;

endpackage

// File: rtl/bip_instr_decoder.sv
// Pure combinational opcode decoder; unknown opcodes fall through as NOP
// (every control zero).
module bip_instr_decoder
   import bip_pkg::*;
(
   input  logic [OPC_W-1:0] i_opcode,
   output ctrl_t            o_ctrl
);

   always_comb begin
      o_ctrl = '0;
      case (i_opcode)
         OPC_STO: o_ctrl.dataWr = 1'b1;
         OPC_LD: begin
            o_ctrl.dataRd = 1'b1;
            o_ctrl.wrAcc  = 1'b1;
            o_ctrl.selA   = SEL_A_MEM;
         end
         OPC_LDI: begin
            o_ctrl.wrAcc = 1'b1;
            o_ctrl.selA  = SEL_A_IMM;
         end
         OPC_ADD: begin
            o_ctrl.dataRd = 1'b1;
            o_ctrl.wrAcc  = 1'b1;
            o_ctrl.selA   = SEL_A_ALU;
            o_ctrl.opCode = 1'b1;
         end
         OPC_ADDI: begin
            o_ctrl.wrAcc  = 1'b1;
            o_ctrl.selA   = SEL_A_ALU;
            o_ctrl.selB   = 1'b1;
            o_ctrl.opCode = 1'b1;
         end
         OPC_SUB: begin
            o_ctrl.dataRd = 1'b1;
            o_ctrl.wrAcc  = 1'b1;
            o_ctrl.selA   = SEL_A_ALU;
         end
         OPC_SUBI: begin
            o_ctrl.wrAcc = 1'b1;
            o_ctrl.selA  = SEL_A_ALU;
            o_ctrl.selB  = 1'b1;
         end
         default: o_ctrl = '0;
      endcase
   end

endmodule

// File: rtl/bip_control_unit.sv
// BIP sequencer: three-cycle FETCH/DECODE/EXEC loop over a sync-read program
// ROM, driving accumulator-datapath controls and data-RAM strobes.
module bip_control_unit
   import bip_pkg::*;
#(
   parameter int NB_BITS = 16,
   parameter int NB_ADDR = 11,
   parameter int NB_OPC  = 5,
   parameter int NB_CYC  = 32
)
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_enable,
   input  logic [NB_BITS-1:0] i_instr,
   output logic [NB_ADDR-1:0] o_instr_addr,
   output logic [NB_ADDR-1:0] o_data_addr,
   output logic               o_data_rd,
   output logic               o_data_wr,
   output logic [NB_ADDR-1:0] o_operand,
   output logic [1:0]         o_sel_a,
   output logic               o_sel_b,
   output logic               o_op_code,
   output logic               o_wr_acc,
   output logic               o_halt,
   output logic [NB_CYC-1:0]  o_cycles
);

   state_t             r_state;
   logic [NB_ADDR-1:0] r_pc;
   logic [NB_BITS-1:0] r_ir;
   logic [NB_CYC-1:0]  r_cycles;

   logic [NB_OPC-1:0]  w_opcode;
   ctrl_t              w_ctrl;
   logic               w_run;

   assign w_run = i_enable && !i_rst;

   // DECODE must see the ROM word before it lands in IR, so it decodes i_instr directly.
   assign w_opcode = (r_state == ST_DECODE) ? i_instr[NB_BITS-1 -: NB_OPC]
                                            : r_ir[NB_BITS-1 -: NB_OPC];

   bip_instr_decoder u_decoder (
      .i_opcode (w_opcode),
      .o_ctrl   (w_ctrl)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_FETCH;
         r_pc     <= '0;
         r_ir     <= '0;
         r_cycles <= '0;
      end else if (i_enable) begin
         if (r_state != ST_HALT && r_cycles != {NB_CYC{1'b1}})
            r_cycles <= r_cycles + 1'b1;
         case (r_state)
            ST_FETCH:  r_state <= ST_DECODE;
            ST_DECODE: begin
               r_ir    <= i_instr;
               r_state <= (i_instr[NB_BITS-1 -: NB_OPC] == OPC_HLT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
               r_pc    <= r_pc + 1'b1;
               r_state <= ST_FETCH;
            end
            default:   r_state <= ST_HALT;
         endcase
      end
   end

   assign o_instr_addr = r_pc;
   assign o_operand    = r_ir[NB_ADDR-1:0];
   assign o_cycles     = r_cycles;

   // Strobes are only live while running; reset and disable both silence them.
   always_comb begin
      o_data_addr = (r_state == ST_DECODE) ? i_instr[NB_ADDR-1:0] : r_ir[NB_ADDR-1:0];
      o_data_rd   = 1'b0;
      o_data_wr   = 1'b0;
      o_sel_a     = SEL_A_MEM;
      o_sel_b     = 1'b0;
      o_op_code   = 1'b0;
      o_wr_acc    = 1'b0;
      o_halt      = (r_state == ST_HALT) && !i_rst;
      if (w_run) begin
         if (r_state == ST_DECODE) begin
            o_data_rd = w_ctrl.dataRd;
         end else if (r_state == ST_EXEC) begin
            o_data_wr = w_ctrl.dataWr;
            o_wr_acc  = w_ctrl.wrAcc;
            o_sel_a   = w_ctrl.selA;
            o_sel_b   = w_ctrl.selB;
            o_op_code = w_ctrl.opCode;
         end
      end
   end

endmodule

// File: tb/tb_bip_control_unit.sv
// Directed bench for bip_control_unit: a behavioural sync-read ROM feeds a
// full-width DUT and a second instance with a 4-bit cycle counter.
module tb_bip_control_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [15:0] rom [0:2047];
   logic [15:0] instr;
   logic [15:0] instrSmall;

   logic [10:0] instrAddr, dataAddr, operand;
   logic        dataRd, dataWr, selB, opCode, wrAcc, halt;
   logic [1:0]  selA;
   logic [31:0] cycles;

   logic [10:0] instrAddrS, dataAddrS, operandS;
   logic        dataRdS, dataWrS, selBS, opCodeS, wrAccS, haltS;
   logic [1:0]  selAS;
   logic [3:0]  cyclesS;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Program ROM with one cycle of read latency for each DUT
   always @(posedge clk) begin
      instr      <= rom[instrAddr];
      instrSmall <= rom[instrAddrS];
   end

   bip_control_unit dut (
      .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_instr(instr),
      .o_instr_addr(instrAddr), .o_data_addr(dataAddr), .o_data_rd(dataRd),
      .o_data_wr(dataWr), .o_operand(operand), .o_sel_a(selA), .o_sel_b(selB),
      .o_op_code(opCode), .o_wr_acc(wrAcc), .o_halt(halt), .o_cycles(cycles)
   );

   bip_control_unit #(.NB_CYC(4)) dutSmall (
      .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_instr(instrSmall),
      .o_instr_addr(instrAddrS), .o_data_addr(dataAddrS), .o_data_rd(dataRdS),
      .o_data_wr(dataWrS), .o_operand(operandS), .o_sel_a(selAS), .o_sel_b(selBS),
      .o_op_code(opCodeS), .o_wr_acc(wrAccS), .o_halt(haltS), .o_cycles(cyclesS)
   );

   // Advance n clock edges and settle 1 time unit past the last one
   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic fillNop();
      for (int i = 0; i < 2048; i++) rom[i] = 16'hF800;
   endtask

   task automatic applyReset();
      rst = 1'b1;
      applyStimulus(1);
      rst = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      enable = 1'b1;
      fillNop();

      // Reset state, observed while reset is still held
      rom[0] = 16'h1805;
      rst = 1'b1;
      applyStimulus(2);
      checkOutput("rst_pc",     {21'd0, instrAddr}, 32'd0);
      checkOutput("rst_cycles", cycles, 32'd0);
      checkOutput("rst_strobe", {28'd0, dataRd, dataWr, wrAcc, halt}, 32'd0);
      rst = 1'b0;

      // LDI 5
      applyStimulus(1);
      checkOutput("ldi_dec_rd", {31'd0, dataRd}, 32'd0);
      applyStimulus(1);
      checkOutput("ldi_wracc",  {31'd0, wrAcc}, 32'd1);
      checkOutput("ldi_sela",   {30'd0, selA}, 32'd1);
      checkOutput("ldi_oper",   {21'd0, operand}, 32'd5);
      applyStimulus(1);
      checkOutput("ldi_pc",     {21'd0, instrAddr}, 32'd1);
      checkOutput("ldi_cycles", cycles, 32'd3);

      // LD 3, ADD 4, STO 7, then reset during STO EXEC
      rom[0] = 16'h1003; rom[1] = 16'h2004; rom[2] = 16'h0807;
      applyReset();
      applyStimulus(1);
      checkOutput("ld_dec_rd",   {31'd0, dataRd}, 32'd1);
      checkOutput("ld_dec_addr", {21'd0, dataAddr}, 32'd3);
      applyStimulus(1);
      checkOutput("ld_exec",     {26'd0, wrAcc, selA, selB, opCode, dataRd}, 32'b100000);
      applyStimulus(2);
      checkOutput("add_dec_rd",   {31'd0, dataRd}, 32'd1);
      checkOutput("add_dec_addr", {21'd0, dataAddr}, 32'd4);
      applyStimulus(1);
      checkOutput("add_exec",    {26'd0, wrAcc, selA, selB, opCode, dataRd}, 32'b110010);
      applyStimulus(2);
      checkOutput("sto_dec_rd",  {31'd0, dataRd}, 32'd0);
      applyStimulus(1);
      checkOutput("sto_exec",    {29'd0, dataWr, wrAcc, dataRd}, 32'b100);
      checkOutput("sto_addr",    {21'd0, dataAddr}, 32'd7);
      checkOutput("sto_cycles",  cycles, 32'd8);
      rst = 1'b1;
      #1;
      checkOutput("rst_sto_wr",  {30'd0, dataWr, wrAcc}, 32'd0);
      applyStimulus(1);
      rst = 1'b0;
      #1;
      checkOutput("rst_sto_pc",     {21'd0, instrAddr}, 32'd0);
      checkOutput("rst_sto_cycles", cycles, 32'd0);
      checkOutput("rst_sto_fetch",  {31'd0, dataRd}, 32'd0);
      applyStimulus(1);
      checkOutput("rst_sto_refetch", {31'd0, dataRd}, 32'd1);

      // SUBI 0x7FF, HLT
      rom[0] = 16'h3FFF; rom[1] = 16'h0000;
      applyReset();
      applyStimulus(2);
      checkOutput("subi_exec",  {27'd0, wrAcc, selA, selB, opCode}, 32'b11010);
      checkOutput("subi_oper",  {21'd0, operand}, 32'h7FF);
      applyStimulus(2);
      checkOutput("hlt_dec_halt", {31'd0, halt}, 32'd0);
      applyStimulus(1);
      checkOutput("hlt_halt",   {31'd0, halt}, 32'd1);
      applyStimulus(5);
      checkOutput("hlt_hold",   {31'd0, halt}, 32'd1);
      checkOutput("hlt_pc",     {21'd0, instrAddr}, 32'd1);
      checkOutput("hlt_cycles", cycles, 32'd5);
      checkOutput("hlt_strobe", {29'd0, dataRd, dataWr, wrAcc}, 32'd0);

      // Disable during EXEC of ADD
      rom[0] = 16'h2004; rom[1] = 16'hF800;
      applyReset();
      applyStimulus(2);
      checkOutput("en_exec_pre", {31'd0, wrAcc}, 32'd1);
      enable = 1'b0;
      #1;
      checkOutput("en_off_strobe", {26'd0, wrAcc, selA, selB, opCode, dataWr}, 32'd0);
      applyStimulus(4);
      checkOutput("en_off_strobe4", {31'd0, wrAcc}, 32'd0);
      checkOutput("en_off_pc",      {21'd0, instrAddr}, 32'd0);
      checkOutput("en_off_cycles",  cycles, 32'd2);
      enable = 1'b1;
      #1;
      checkOutput("en_resume", {26'd0, wrAcc, selA, selB, opCode, dataWr}, 32'b110010);
      applyStimulus(1);
      checkOutput("en_after_wracc", {31'd0, wrAcc}, 32'd0);
      checkOutput("en_after_pc",    {21'd0, instrAddr}, 32'd1);
      checkOutput("en_after_cyc",   cycles, 32'd3);

      // NOP sweep: PC wrap and counter saturation in the 4-bit instance
      fillNop();
      applyReset();
      applyStimulus(2);
      checkOutput("nop_exec", {29'd0, dataRd, dataWr, wrAcc}, 32'd0);
      applyStimulus(8);
      checkOutput("small_cyc10", {28'd0, cyclesS}, 32'd10);
      applyStimulus(3 * 2047 - 10);
      checkOutput("nop_pc_max",  {21'd0, instrAddr}, 32'h7FF);
      applyStimulus(3);
      checkOutput("nop_pc_wrap", {21'd0, instrAddr}, 32'd0);
      checkOutput("nop_cycles",  cycles, 32'd6144);
      checkOutput("small_sat",   {28'd0, cyclesS}, 32'd15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
